// File: rtl/pcie_nvme_pkg.sv
// Shared definitions for the PCIe/NVMe datapath blocks of computer_system.
//   LTSSM_L0   : LTSSM encoding of the L0 (link up) state, used by the link_up synchroniser
//   TX_DATA_W  : Avalon-ST TX beat payload width carried by tx_beat_t
//   arb_state_t: TX arbiter FSM states
//   tx_beat_t  : one registered TX beat {sop, eop, data}
package pcie_nvme_pkg;

    localparam logic [4:0] LTSSM_L0  = 5'h0F;
    localparam int         TX_DATA_W = 64;

    typedef enum logic {
        ARB_IDLE,
        ARB_PKT
    } arb_state_t;

    typedef struct packed {
        logic                 sop;
        logic                 eop;
        logic [TX_DATA_W-1:0] data;
    } tx_beat_t;

endpackage

// File: rtl/pcie_tx_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority selector.
//   valid  : per-requester request vector
//   rr_ptr : index with highest priority this round
//   idx    : first set index found scanning rr_ptr, rr_ptr+1, ... (mod N_REQ)
//   any    : 1 when at least one valid bit is set (idx is 0 otherwise)
module rr_pick #(
    parameter int N_REQ = 3
) (
    input  logic [N_REQ-1:0]         valid,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [$clog2(N_REQ)-1:0] idx,
    output logic                     any
);

    localparam int IW = $clog2(N_REQ);

    // cand[k] is the requester examined at priority rank k. rr_ptr < N_REQ
    // and k < N_REQ, so one conditional subtraction performs the modulo.
    logic [IW:0]   sum  [N_REQ];
    logic [IW-1:0] cand [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign sum[gi]  = {1'b0, rr_ptr} + (IW+1)'(gi);
            assign cand[gi] = (sum[gi] >= (IW+1)'(N_REQ)) ?
                              IW'(sum[gi] - (IW+1)'(N_REQ)) : sum[gi][IW-1:0];
        end
    endgenerate

    // Walk from lowest to highest priority so the highest-priority hit wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (valid[cand[i]]) begin
                any = 1'b1;
                idx = cand[i];
            end
        end
    end

endmodule

// File: rtl/pcie_tx_rr_arbiter.sv
// pcie_tx_rr_arbiter: shares the PCIe HIP Avalon-ST TX port among N_REQ TLP
// sources. Packets are arbitrated round-robin, the grant is held from SOP to
// EOP, and every forwarded beat passes through one output register.
//   clk_clk, reset_reset      : HIP application clock, synchronous active-high reset
//   link_up                   : grants are only issued while the link is in L0
//   req_valid/sop/eop/data    : per-requester Avalon-ST sources (data packed i*DATA_W)
//   req_ready                 : at most one bit set, for the granted requester
//   tx_st_valid/sop/eop/data  : registered HIP TX beat; tx_st_ready has readyLatency 0
//   grant_id                  : requester holding the current or last grant
//   busy                      : 1 while a packet is being forwarded
//   pkt_count                 : EOP beats delivered to the HIP (wraps)
//   err_framing, err_oversize : sticky error flags, cleared only by reset
// DATA_W is expected to equal TX_DATA_W, the payload width of tx_beat_t.
module pcie_tx_rr_arbiter
    import pcie_nvme_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int DATA_W    = TX_DATA_W,
    parameter int MAX_BEATS = 64
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset,
    input  logic                      link_up,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_sop,
    input  logic [N_REQ-1:0]          req_eop,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      tx_st_valid,
    output logic                      tx_st_sop,
    output logic                      tx_st_eop,
    output logic [DATA_W-1:0]         tx_st_data,
    input  logic                      tx_st_ready,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      busy,
    output logic [15:0]               pkt_count,
    output logic                      err_framing,
    output logic                      err_oversize
);

    localparam int GW  = $clog2(N_REQ);
    localparam int BCW = $clog2(MAX_BEATS + 1);

    arb_state_t     state_reg, state_next;
    logic [GW-1:0]  grant_id_reg;
    logic [GW-1:0]  rr_ptr_reg;
    logic [BCW-1:0] beat_cnt_reg;
    logic [BCW-1:0] beat_cnt_inc;
    tx_beat_t       tx_beat_reg;
    logic           tx_valid_reg;
    logic [15:0]    pkt_count_reg;
    logic           err_framing_reg;
    logic           err_oversize_reg;

    logic [DATA_W-1:0] req_data_arr [N_REQ];
    logic [GW-1:0]     pick_idx;
    logic              pick_any;
    logic              start_grant;
    logic              out_free;
    logic              accept;
    logic              last_accept;
    logic              g_sop;
    logic              g_eop;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign req_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .valid  (req_valid),
        .rr_ptr (rr_ptr_reg),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // The output register can take a new beat when empty or draining this cycle.
    assign out_free    = ~tx_valid_reg | tx_st_ready;
    assign start_grant = (state_reg == ARB_IDLE) & link_up & pick_any;
    assign g_sop       = req_sop[grant_id_reg];
    assign g_eop       = req_eop[grant_id_reg];
    assign accept      = (state_reg == ARB_PKT) & req_valid[grant_id_reg] & out_free;
    assign last_accept = accept & g_eop;

    // Saturate so a runaway packet cannot wrap back into "first beat".
    assign beat_cnt_inc = (beat_cnt_reg == '1) ? beat_cnt_reg : beat_cnt_reg + 1'b1;

    // FSM: state register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_reg <= ARB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state. A dropped link_up does not end a packet early.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE: if (start_grant) state_next = ARB_PKT;
            ARB_PKT:  if (last_accept) state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready = '0;
        if (state_reg == ARB_PKT) begin
            req_ready[grant_id_reg] = out_free;
        end
    end

    // Grant bookkeeping, output register, counters and error flags.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            grant_id_reg     <= '0;
            rr_ptr_reg       <= '0;
            beat_cnt_reg     <= '0;
            tx_valid_reg     <= 1'b0;
            tx_beat_reg      <= '0;
            pkt_count_reg    <= '0;
            err_framing_reg  <= 1'b0;
            err_oversize_reg <= 1'b0;
        end else begin
            if (start_grant) begin
                grant_id_reg <= pick_idx;
                beat_cnt_reg <= '0;
            end

            if (accept) begin
                tx_valid_reg     <= 1'b1;
                tx_beat_reg.sop  <= g_sop;
                tx_beat_reg.eop  <= g_eop;
                tx_beat_reg.data <= TX_DATA_W'(req_data_arr[grant_id_reg]);
                beat_cnt_reg     <= beat_cnt_inc;
                // First beat must carry SOP; no later beat may.
                if ((beat_cnt_reg == '0) ? ~g_sop : g_sop) begin
                    err_framing_reg <= 1'b1;
                end
                if (~g_eop && (beat_cnt_inc == BCW'(MAX_BEATS))) begin
                    err_oversize_reg <= 1'b1;
                end
            end else if (tx_st_ready) begin
                tx_valid_reg <= 1'b0;
            end

            if (last_accept) begin
                rr_ptr_reg <= (grant_id_reg == GW'(N_REQ - 1)) ? '0 : grant_id_reg + 1'b1;
            end

            // Count packets as they actually leave toward the HIP.
            if (tx_valid_reg & tx_st_ready & tx_beat_reg.eop) begin
                pkt_count_reg <= pkt_count_reg + 16'd1;
            end
        end
    end

    assign tx_st_valid  = tx_valid_reg;
    assign tx_st_sop    = tx_beat_reg.sop;
    assign tx_st_eop    = tx_beat_reg.eop;
    assign tx_st_data   = DATA_W'(tx_beat_reg.data);
    assign grant_id     = grant_id_reg;
    assign busy         = (state_reg == ARB_PKT);
    assign pkt_count    = pkt_count_reg;
    assign err_framing  = err_framing_reg;
    assign err_oversize = err_oversize_reg;

endmodule

// File: tb/tb_pcie_tx_rr_arbiter.sv
// Directed testbench for pcie_tx_rr_arbiter. Each requester is modelled as a
// queue of beats; every accepted beat is pushed to a scoreboard and popped
// when it is handed to the HIP side, so order, loss and duplication are checked.
module tb_pcie_tx_rr_arbiter;

    localparam int N  = 3;
    localparam int DW = 64;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
    } beat_t;

    logic            clk_clk = 1'b0;
    logic            reset_reset;
    logic            link_up;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_sop;
    logic [N-1:0]    req_eop;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            tx_st_valid;
    logic            tx_st_sop;
    logic            tx_st_eop;
    logic [DW-1:0]   tx_st_data;
    logic            tx_st_ready;
    logic [1:0]      grant_id;
    logic            busy;
    logic [15:0]     pkt_count;
    logic            err_framing;
    logic            err_oversize;

    always #5 clk_clk = ~clk_clk;

    pcie_tx_rr_arbiter #(
        .N_REQ     (N),
        .DATA_W    (DW),
        .MAX_BEATS (64)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .link_up      (link_up),
        .req_valid    (req_valid),
        .req_sop      (req_sop),
        .req_eop      (req_eop),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .tx_st_valid  (tx_st_valid),
        .tx_st_sop    (tx_st_sop),
        .tx_st_eop    (tx_st_eop),
        .tx_st_data   (tx_st_data),
        .tx_st_ready  (tx_st_ready),
        .grant_id     (grant_id),
        .busy         (busy),
        .pkt_count    (pkt_count),
        .err_framing  (err_framing),
        .err_oversize (err_oversize)
    );

    beat_t       rq [N][$];
    beat_t       sb [$];
    int          grant_log [$];
    int          sop_cyc [$];
    int          acc_cnt [N];
    int          cyc     = 0;
    int          n_pass  = 0;
    int          n_total = 0;
    int          n_fail  = 0;
    bit          toggle  = 1'b0;
    bit          chk_ovs = 1'b0;
    bit          prev_stall = 1'b0;
    logic [65:0] prev_beat;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int r, input int len, input bit with_sop);
        beat_t x;
        for (int b = 0; b < len; b++) begin
            x.sop  = with_sop && (b == 0);
            x.eop  = (b == len - 1);
            x.data = {8'(r), 24'($urandom), 32'(b)};
            rq[r].push_back(x);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() != 0) begin
                req_valid[i]           = 1'b1;
                req_sop[i]             = rq[i][0].sop;
                req_eop[i]             = rq[i][0].eop;
                req_data[i*DW +: DW]   = rq[i][0].data;
            end else begin
                req_valid[i]           = 1'b0;
                req_sop[i]             = 1'b0;
                req_eop[i]             = 1'b0;
                req_data[i*DW +: DW]   = '0;
            end
        end
    endtask

    // One clock: observe at the negedge, advance the source models after the posedge.
    task automatic cycle();
        logic [N-1:0] acc;
        beat_t        e;
        @(negedge clk_clk);
        cyc++;
        if (prev_stall) begin
            check("stall_hold", {tx_st_sop, tx_st_eop, tx_st_data}, prev_beat);
            check("stall_valid", tx_st_valid, 1'b1);
        end
        check("ready_onehot", ($countones(req_ready) <= 1), 1'b1);
        check("ready_when_idle", (!busy && (req_ready != '0)), 1'b0);
        if (tx_st_valid && tx_st_ready) begin
            if (sb.size() == 0) begin
                check("tx_unexpected_beat", {tx_st_sop, tx_st_eop, tx_st_data}, 66'd0);
            end else begin
                e = sb.pop_front();
                check("tx_beat", {tx_st_sop, tx_st_eop, tx_st_data}, e);
            end
            if (tx_st_sop) sop_cyc.push_back(cyc);
        end
        prev_stall = tx_st_valid && !tx_st_ready;
        prev_beat  = {tx_st_sop, tx_st_eop, tx_st_data};
        for (int i = 0; i < N; i++) begin
            acc[i] = req_valid[i] & req_ready[i];
            if (acc[i]) begin
                sb.push_back(rq[i][0]);
                if (rq[i][0].sop) grant_log.push_back(i);
            end
        end
        if (chk_ovs) check("err_oversize_track", err_oversize, (acc_cnt[0] >= 64));
        @(posedge clk_clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                void'(rq[i].pop_front());
                acc_cnt[i]++;
            end
        end
        if (toggle) tx_st_ready = ~tx_st_ready;
        drive();
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() != 0) return 1'b1;
        end
        return (sb.size() != 0) || (tx_st_valid === 1'b1);
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            cycle();
            n++;
        end
        check("drain_in_budget", (n < budget), 1'b1);
    endtask

    initial begin
        int exp_order [4];
        int n;

        reset_reset = 1'b1;
        link_up     = 1'b0;
        tx_st_ready = 1'b1;
        req_valid   = '0;
        req_sop     = '0;
        req_eop     = '0;
        req_data    = '0;
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;

        // Reset state
        repeat (3) @(posedge clk_clk);
        @(negedge clk_clk);
        check("rst_tx_valid", tx_st_valid, 1'b0);
        check("rst_tx_fields", {tx_st_sop, tx_st_eop, tx_st_data}, 66'd0);
        check("rst_req_ready", req_ready, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_grant_id", grant_id, 2'd0);
        check("rst_pkt_count", pkt_count, 16'd0);
        check("rst_errors", {err_framing, err_oversize}, 2'b00);
        @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;

        // 1: link down blocks all grants
        add_pkt(0, 2, 1'b1);
        add_pkt(1, 2, 1'b1);
        add_pkt(2, 2, 1'b1);
        drive();
        for (int k = 0; k < 20; k++) begin
            cycle();
            check("linkdown_req_ready", req_ready, 3'b000);
            check("linkdown_tx_valid", tx_st_valid, 1'b0);
        end

        // 2: round robin 0,1,2,0 with continuous 2-beat packets
        add_pkt(0, 2, 1'b1);
        drive();
        link_up = 1'b1;
        drain(200);
        exp_order = '{0, 1, 2, 0};
        check("rr_grant_count", grant_log.size(), 4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++) begin
            check("rr_grant_order", grant_log[k], exp_order[k]);
        end
        check("rr_pkt_count", pkt_count, 16'd4);
        grant_log.delete();

        // 3: back-pressure 1010 during a 4-beat packet from requester 1
        add_pkt(1, 4, 1'b1);
        drive();
        toggle = 1'b1;
        drain(100);
        toggle      = 1'b0;
        tx_st_ready = 1'b1;
        check("bp_grant", (grant_log.size() == 1) && (grant_log[0] == 1), 1'b1);
        check("bp_pkt_count", pkt_count, 16'd5);
        grant_log.delete();

        // 4: single-beat TLPs from req 2 then req 0, one idle TX cycle apart
        sop_cyc.delete();
        add_pkt(2, 1, 1'b1);
        add_pkt(0, 1, 1'b1);
        drive();
        drain(50);
        check("one_beat_grants", (grant_log.size() == 2) && (grant_log[0] == 2) && (grant_log[1] == 0), 1'b1);
        check("one_beat_gap", (sop_cyc.size() == 2) ? (sop_cyc[1] - sop_cyc[0]) : -1, 2);
        check("one_beat_pkt_count", pkt_count, 16'd7);
        grant_log.delete();

        // 5a: 65-beat packet sets err_oversize at beat 64, all beats forwarded
        acc_cnt[0] = 0;
        chk_ovs    = 1'b1;
        add_pkt(0, 65, 1'b1);
        drive();
        drain(300);
        chk_ovs = 1'b0;
        check("ovs_beats_accepted", acc_cnt[0], 65);
        check("ovs_flag", err_oversize, 1'b1);
        check("ovs_no_framing", err_framing, 1'b0);
        check("ovs_pkt_count", pkt_count, 16'd8);

        // 5b: packet without SOP sets err_framing and is forwarded unchanged
        add_pkt(1, 2, 1'b0);
        drive();
        drain(50);
        check("framing_flag", err_framing, 1'b1);
        check("framing_pkt_count", pkt_count, 16'd9);
        grant_log.delete();

        // 6: reset at beat 2 of a 4-beat packet from requester 2
        acc_cnt[2] = 0;
        add_pkt(2, 4, 1'b1);
        drive();
        n = 0;
        while (acc_cnt[2] < 2 && n < 50) begin
            cycle();
            n++;
        end
        check("mid_pkt_reach_beat2", acc_cnt[2], 2);
        rq[2].delete();
        drive();
        reset_reset = 1'b1;
        @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
        sb.delete();
        grant_log.delete();
        prev_stall = 1'b0;
        @(negedge clk_clk);
        check("midrst_tx_valid", tx_st_valid, 1'b0);
        check("midrst_tx_fields", {tx_st_sop, tx_st_eop, tx_st_data}, 66'd0);
        check("midrst_req_ready", req_ready, 3'b000);
        check("midrst_busy", busy, 1'b0);
        check("midrst_grant_id", grant_id, 2'd0);
        check("midrst_pkt_count", pkt_count, 16'd0);
        check("midrst_errors", {err_framing, err_oversize}, 2'b00);
        add_pkt(2, 1, 1'b1);
        add_pkt(0, 1, 1'b1);
        drive();
        drain(50);
        check("post_rst_first_grant", (grant_log.size() >= 1) ? grant_log[0] : -1, 0);
        check("post_rst_pkt_count", pkt_count, 16'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
